// File: rtl/stage_wb_pkg.sv
// stage_wb_pkg: shared widths, write-back source selects, load funct3 codes and FSM states.
package stage_wb_pkg;
    localparam int REG_ADDR_WIDTH = 5;
    localparam int MEM_ADDR_WIDTH = 32;
    localparam int WORD_WIDTH = 32;
    localparam logic [1:0] WB_SRC_ALU = 2'b00;
    localparam logic [1:0] WB_SRC_MEM = 2'b01;
    localparam logic [1:0] WB_SRC_PC4 = 2'b10;
    localparam logic [1:0] WB_SRC_RSV = 2'b11;
    localparam logic [2:0] LD_B = 3'b000;
    localparam logic [2:0] LD_H = 3'b001;
    localparam logic [2:0] LD_W = 3'b010;
    localparam logic [2:0] LD_BU = 3'b100;
    localparam logic [2:0] LD_HU = 3'b101;
    typedef enum logic {WB_RUN = 1'b0, WB_WAIT = 1'b1} wb_state_t;
endpackage

// File: rtl/stage_wb_load_extender.sv
// load_extender: picks the byte/half lane of an aligned word and extends it; flags bad type or alignment.
module load_extender
    import stage_wb_pkg::*;
#(
    parameter int word_width = WORD_WIDTH
) (
    input  logic [word_width-1:0] rdata,
    input  logic [2:0]            byt_typ,
    input  logic [1:0]            byte_off,
    output logic [word_width-1:0] data,
    output logic                  bad
);
    logic [7:0]  b;
    logic [15:0] h;
    assign b = rdata[{byte_off, 3'b000} +: 8];
    assign h = rdata[{byte_off[1], 4'b0000} +: 16];
    always_comb begin
        data = rdata;
        bad = 1'b0;
        case (byt_typ)
            LD_B:  data = {{(word_width-8){b[7]}}, b};
            LD_BU: data = {{(word_width-8){1'b0}}, b};
            LD_H: begin
                data = {{(word_width-16){h[15]}}, h};
                bad = byte_off[0];
            end
            LD_HU: begin
                data = {{(word_width-16){1'b0}}, h};
                bad = byte_off[0];
            end
            LD_W:  bad = |byte_off;
            default: bad = 1'b1;
        endcase
    end
endmodule

// File: rtl/stage_wb.sv
// stage_wb: write-back stage; registers MEM results, selects the rd source and stalls on slow loads.
module stage_wb
    import stage_wb_pkg::*;
#(
    parameter int reg_addr_width = REG_ADDR_WIDTH,
    parameter int ins_addr_width = MEM_ADDR_WIDTH,
    parameter int word_width = WORD_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      valid_in,
    input  logic [reg_addr_width-1:0] rd_addr_in,
    input  logic                      rd_wen_in,
    input  logic [1:0]                wb_ctl_in,
    input  logic [2:0]                byt_typ_in,
    input  logic [1:0]                byte_off_in,
    input  logic [word_width-1:0]     alu_res_in,
    input  logic [ins_addr_width-1:0] pc_addr_in,
    input  logic                      dmem_rvalid,
    input  logic [word_width-1:0]     dmem_rdata,
    output logic [reg_addr_width-1:0] rd_addr_out,
    output logic                      rd_wen_out,
    output logic [word_width-1:0]     wb_out,
    output logic                      stall_out,
    output logic                      err_out
);
    wb_state_t state, state_nxt;
    logic [reg_addr_width-1:0] hold_rd, addr_nxt;
    logic                      hold_wen, wen_nxt, err_nxt, capture;
    logic [2:0]                hold_typ;
    logic [1:0]                hold_off;
    logic [word_width-1:0]     ext_data, data_nxt, pc4;
    logic                      ext_bad;
    logic                      waiting;

    assign waiting = state == WB_WAIT;
    assign stall_out = waiting;
    assign pc4 = word_width'(pc_addr_in) + word_width'(4);

    // While waiting, the lane/type come from the captured load, not the stalled upstream
    load_extender #(.word_width(word_width)) u_ext (
        .rdata(dmem_rdata),
        .byt_typ(waiting ? hold_typ : byt_typ_in),
        .byte_off(waiting ? hold_off : byte_off_in),
        .data(ext_data),
        .bad(ext_bad)
    );

    always_comb begin
        state_nxt = state;
        addr_nxt = rd_addr_out;
        data_nxt = wb_out;
        wen_nxt = 1'b0;
        err_nxt = 1'b0;
        capture = 1'b0;
        if (waiting) begin
            if (dmem_rvalid) begin
                state_nxt = WB_RUN;
                addr_nxt = hold_rd;
                data_nxt = ext_data;
                wen_nxt = hold_wen && |hold_rd;
            end
        end else if (valid_in) begin
            if (wb_ctl_in == WB_SRC_RSV || (wb_ctl_in == WB_SRC_MEM && ext_bad)) begin
                err_nxt = 1'b1;
            end else if (wb_ctl_in == WB_SRC_MEM && !dmem_rvalid) begin
                capture = 1'b1;
                state_nxt = WB_WAIT;
            end else begin
                addr_nxt = rd_addr_in;
                data_nxt = wb_ctl_in == WB_SRC_MEM ? ext_data :
                           wb_ctl_in == WB_SRC_PC4 ? pc4 : alu_res_in;
                wen_nxt = rd_wen_in && |rd_addr_in;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= WB_RUN;
            rd_addr_out <= '0;
            wb_out <= '0;
            rd_wen_out <= 1'b0;
            err_out <= 1'b0;
            hold_rd <= '0;
            hold_wen <= 1'b0;
            hold_typ <= '0;
            hold_off <= '0;
        end else begin
            state <= state_nxt;
            rd_addr_out <= addr_nxt;
            wb_out <= data_nxt;
            rd_wen_out <= wen_nxt;
            err_out <= err_nxt;
            if (capture) begin
                hold_rd <= rd_addr_in;
                hold_wen <= rd_wen_in;
                hold_typ <= byt_typ_in;
                hold_off <= byte_off_in;
            end
        end
    end
endmodule

// File: tb/tb_stage_wb.sv
// tb_stage_wb: directed test-plan sequences plus random traffic checked against a behavioural model.
module tb_stage_wb;
    logic        clk = 1'b0;
    logic        rst, valid_in, rd_wen_in, dmem_rvalid;
    logic [4:0]  rd_addr_in;
    logic [1:0]  wb_ctl_in, byte_off_in;
    logic [2:0]  byt_typ_in;
    logic [31:0] alu_res_in, pc_addr_in, dmem_rdata;
    logic [4:0]  rd_addr_out;
    logic        rd_wen_out, stall_out, err_out;
    logic [31:0] wb_out;

    int n_chk = 0;
    int n_err = 0;

    bit          pend;
    logic [4:0]  pend_rd;
    bit          pend_wen;
    logic [2:0]  pend_typ;
    logic [1:0]  pend_off;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    bit          e_wen, e_err, e_rst;

    stage_wb dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .rd_addr_in(rd_addr_in),
        .rd_wen_in(rd_wen_in), .wb_ctl_in(wb_ctl_in), .byt_typ_in(byt_typ_in),
        .byte_off_in(byte_off_in), .alu_res_in(alu_res_in), .pc_addr_in(pc_addr_in),
        .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata), .rd_addr_out(rd_addr_out),
        .rd_wen_out(rd_wen_out), .wb_out(wb_out), .stall_out(stall_out), .err_out(err_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Load value from funct3 rules using shifts and arithmetic on the whole word
    function automatic logic [31:0] load_val(input logic [31:0] w, input logic [2:0] t, input logic [1:0] o);
        int unsigned bv, hv;
        bv = (w >> (8 * int'(o))) & 32'hFF;
        hv = (w >> (16 * int'(o[1]))) & 32'hFFFF;
        case (t)
            3'd0: return bv >= 128 ? bv - 256 : bv;
            3'd1: return hv >= 32768 ? hv - 65536 : hv;
            3'd4: return bv;
            3'd5: return hv;
            default: return w;
        endcase
    endfunction

    function automatic bit load_ok(input logic [2:0] t, input logic [1:0] o);
        if (t == 3'd0 || t == 3'd4) return 1;
        if (t == 3'd1 || t == 3'd5) return o % 2 == 0;
        if (t == 3'd2) return o == 0;
        return 0;
    endfunction

    task automatic write_exp(input logic [4:0] a, input logic [31:0] d, input bit w);
        e_addr = a;
        e_data = d;
        e_wen = w && a != 0;
    endtask

    task automatic model();
        e_wen = 0;
        e_err = 0;
        e_rst = rst;
        if (rst) begin
            pend = 0;
            e_addr = 0;
            e_data = 0;
        end else if (pend) begin
            if (dmem_rvalid) begin
                write_exp(pend_rd, load_val(dmem_rdata, pend_typ, pend_off), pend_wen);
                pend = 0;
            end
        end else if (valid_in) begin
            if (wb_ctl_in == 2'd3 || (wb_ctl_in == 2'd1 && !load_ok(byt_typ_in, byte_off_in)))
                e_err = 1;
            else if (wb_ctl_in == 2'd1 && !dmem_rvalid) begin
                pend = 1;
                pend_rd = rd_addr_in;
                pend_wen = rd_wen_in;
                pend_typ = byt_typ_in;
                pend_off = byte_off_in;
            end else if (wb_ctl_in == 2'd1)
                write_exp(rd_addr_in, load_val(dmem_rdata, byt_typ_in, byte_off_in), rd_wen_in);
            else if (wb_ctl_in == 2'd2)
                write_exp(rd_addr_in, pc_addr_in + 4, rd_wen_in);
            else
                write_exp(rd_addr_in, alu_res_in, rd_wen_in);
        end
    endtask

    task automatic step();
        model();
        @(posedge clk);
        #1;
        chk("rd_wen", 32'(rd_wen_out), 32'(e_wen));
        chk("err", 32'(err_out), 32'(e_err));
        chk("stall", 32'(stall_out), 32'(pend));
        if (e_wen || e_rst) begin
            chk("rd_addr", 32'(rd_addr_out), 32'(e_addr));
            chk("wb_data", wb_out, e_data);
        end
    endtask

    task automatic drive(input bit v, input logic [1:0] ctl, input logic [4:0] rd, input logic [2:0] typ,
                         input logic [1:0] off, input logic [31:0] alu, input bit rv, input logic [31:0] rdat);
        valid_in = v;
        wb_ctl_in = ctl;
        rd_addr_in = rd;
        rd_wen_in = 1'b1;
        byt_typ_in = typ;
        byte_off_in = off;
        alu_res_in = alu;
        dmem_rvalid = rv;
        dmem_rdata = rdat;
    endtask

    initial begin
        rst = 1'b1;
        pc_addr_in = 32'h0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        step();
        step();
        rst = 1'b0;
        drive(1, 2'd0, 5, 0, 0, 32'hDEADBEEF, 0, 0); step();
        drive(0, 2'd0, 5, 0, 0, 0, 0, 0); step();
        pc_addr_in = 32'h100;
        drive(1, 2'd2, 1, 0, 0, 0, 0, 0); step();
        drive(1, 2'd2, 0, 0, 0, 0, 0, 0); step();
        drive(1, 2'd1, 3, 3'd0, 2'd3, 0, 1, 32'h80FF7F01); step();
        drive(1, 2'd1, 4, 3'd4, 2'd1, 0, 1, 32'h80FF7F01); step();
        drive(1, 2'd1, 6, 3'd1, 2'd2, 0, 1, 32'h80FF7F01); step();
        drive(1, 2'd1, 8, 3'd5, 2'd0, 0, 1, 32'h80FF7F01); step();
        drive(1, 2'd1, 7, 3'd2, 2'd0, 0, 0, 0); step();
        drive(1, 2'd0, 9, 0, 0, 32'hA5A5A5A5, 0, 0); step();
        step();
        dmem_rvalid = 1'b1;
        dmem_rdata = 32'h12345678;
        step();
        dmem_rvalid = 1'b0;
        step();
        drive(1, 2'd1, 10, 3'd1, 2'd1, 0, 0, 0); step();
        drive(1, 2'd3, 11, 0, 0, 0, 0, 0); step();
        drive(1, 2'd1, 12, 3'd2, 2'd0, 0, 0, 0); step();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1; step();
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 1, 32'hCAFEF00D); step();
        step();
        for (int i = 0; i < 600; i++) begin
            rst = $urandom_range(0, 99) < 2;
            pc_addr_in = $urandom;
            drive($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), 5'($urandom), 3'($urandom),
                  2'($urandom), $urandom, $urandom_range(0, 9) < 4, $urandom);
            rd_wen_in = $urandom_range(0, 7) != 0;
            step();
        end
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/stage_wb.md
Name: stage_wb

Overview:
- Write-back stage of the 5-stage RISC-V pipeline.
- Drives the register-file write port consumed by the decode stage: rd_addr, rd_wen, wb_out.
- Registers MEM-stage results and selects the write-back source (ALU, load data, PC+4).
- Sign/zero-extends sub-word loads and stalls upstream while a multi-cycle data-memory read response is outstanding.

Parameters:
- reg_addr_width, `REG_ADDR_WIDTH (5): register address width.
- ins_addr_width, `MEM_ADDR_WIDTH (32): PC width.
- word_width, `WORD_WIDTH (32): datapath width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous active-high reset.
- valid_in  in  1  MEM stage presents an instruction this cycle.
- rd_addr_in  in  reg_addr_width  destination register.
- rd_wen_in  in  1  instruction writes rd.
- wb_ctl_in  in  2  source select: 00 ALU, 01 load, 10 PC+4, 11 reserved.
- byt_typ_in  in  3  load funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- byte_off_in  in  2  load address bits [1:0].
- alu_res_in  in  word_width  ALU result.
- pc_addr_in  in  ins_addr_width  instruction PC.
- dmem_rvalid  in  1  load data valid this cycle.
- dmem_rdata  in  word_width  aligned 32-bit memory word.
- rd_addr_out  out  reg_addr_width  register-file write address.
- rd_wen_out  out  1  register-file write enable, one-cycle pulse.
- wb_out  out  word_width  register-file write data.
- stall_out  out  1  MEM stage must hold its outputs.
- err_out  out  1  one-cycle pulse: illegal wb_ctl, byt_typ, or misaligned load.

Behaviour:
- Reset:
  - state=RUN.
  - rd_addr_out=0, rd_wen_out=0, wb_out=0, stall_out=0, err_out=0.
  - A pending load in WAIT is discarded; no write occurs.
- State machine, 2 states (RUN, WAIT):
  - stall_out = (state==WAIT); it decodes registered state and has no combinational path from the inputs.
- RUN, valid_in=1, non-load (wb_ctl 00/10):
  - Next edge: rd_addr_out=rd_addr_in, wb_out = ALU result or pc_addr_in+4 (modulo 2^word_width), rd_wen_out=rd_wen_in.
  - Latency 1 cycle.
- RUN, valid_in=1, load, dmem_rvalid=1 in the same cycle: same as non-load, with wb_out = extended load data. Latency 1.
- RUN, valid_in=1, load, dmem_rvalid=0:
  - Capture rd_addr, rd_wen, byt_typ and byte_off into hold registers; go to WAIT.
  - rd_wen_out=0 next cycle.
- WAIT:
  - valid_in is ignored; upstream holds its instruction because stall_out=1.
  - On dmem_rvalid=1: next edge outputs the write from the hold registers plus extended data, state returns to RUN, stall_out=0.
  - The held upstream instruction is accepted on the following cycle.
- dmem_rvalid in RUN with no load presented: ignored.
- RUN, valid_in=0: rd_wen_out=0, err_out=0; rd_addr_out and wb_out hold their previous values.
- Load extraction:
  - LB/LBU: byte lane byte_off, sign- or zero-extended.
  - LH/LHU: half selected by byte_off[1]; byte_off[0] must be 0.
  - LW: byte_off must be 00.
- x0 rule: rd_wen_out forced 0 whenever the written rd_addr is 0.
- Error pulse: err_out=1 for one cycle in place of a write (rd_wen_out=0) when:
  - wb_ctl=11, or
  - a load has illegal byt_typ (011, 110, 111), or
  - a load is misaligned.
- Misaligned or illegal-type loads are detected when accepted; no WAIT is entered and the response is not awaited.
- Simultaneous events:
  - rst outranks everything.
  - In WAIT, rvalid and a new valid_in arriving together: only the pending load completes.

Decomposition:
- constants.vh gains:
  - WB_SRC_ALU / WB_SRC_MEM / WB_SRC_PC4 / WB_SRC_RSV encodings.
  - Load funct3 codes.
  - WB_RUN / WB_WAIT state encodings.
- One sub-module: load_extender (combinational: rdata, byt_typ, byte_off -> data, misaligned/illegal flag).

Test Plan:
- Reset then ALU op: valid_in, wb_ctl=00, rd=5, alu=0xDEADBEEF -> next cycle rd_wen_out=1, rd_addr_out=5, wb_out=0xDEADBEEF; one cycle later rd_wen_out=0.
- JAL write: wb_ctl=10, pc=0x100, rd=1 -> wb_out=0x104. Same with rd=0 -> rd_wen_out stays 0.
- Zero-wait loads with rdata=0x80FF7F01:
  - LB off=3 -> 0xFFFFFF80.
  - LBU off=1 -> 0x0000007F.
  - LH off=2 -> 0xFFFF80FF.
  - LHU off=0 -> 0x00007F01.
- Multi-cycle load: LW rd=7 with rvalid low 3 cycles.
  - stall_out=1 for 3 cycles; the new valid_in presented during WAIT is ignored.
  - rvalid with 0x12345678 -> next cycle write rd=7, 0x12345678, stall_out=0.
  - Held ALU op retires on the following cycle.
- Errors:
  - LH off=1 -> err_out pulse, no write, no stall.
  - wb_ctl=11 -> err_out pulse, no write.
- rst asserted in WAIT -> next cycle stall_out=0, no write; a later rvalid is ignored.
